// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for bcd_to_bin_seq: BCD word in, binary result plus flags out.
// dat_gray_o exists only when BCD2BIN_GRAY_EN is defined.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [4*DIGITS-1:0]   dat_bcd_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [BIN_W-1:0]      dat_bin_o;
  logic                  err_o;
  logic                  ovf_o;
`ifdef BCD2BIN_GRAY_EN
  logic [BIN_W-1:0]      dat_gray_o;
`endif

  // Converter side.
  modport slave (
    input  in_valid_i, dat_bcd_i, out_ready_i,
    output in_ready_o, out_valid_o, dat_bin_o, err_o, ovf_o
`ifdef BCD2BIN_GRAY_EN
    , output dat_gray_o
`endif
  );

  // Producer/consumer side.
  modport master (
    output in_valid_i, dat_bcd_i, out_ready_i,
    input  in_ready_o, out_valid_o, dat_bin_o, err_o, ovf_o
`ifdef BCD2BIN_GRAY_EN
    , input dat_gray_o
`endif
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one multiply-by-10-and-add per cycle, MSD first.
// Optional Gray-coded result output enabled by defining BCD2BIN_GRAY_EN.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bcd_to_bin_seq_if.slave  bus
);
  localparam int SR_W   = 4 * DIGITS;
  localparam int FULL_W = BIN_W + 5;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q;
  logic [SR_W-1:0]   shift_q;
  logic [BIN_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              ovf_q;

  logic [3:0]        dig;
  logic [FULL_W-1:0] step_full;
  logic [BIN_W-1:0]  step_res;
  logic              step_ovf;
  logic              accept;

  // The step is evaluated wide enough that overflow is visible before truncation.
  assign dig       = shift_q[SR_W-1 -: 4];
  assign step_full = FULL_W'(acc_q) * FULL_W'(10) + FULL_W'(dig);
  assign step_res  = step_full[BIN_W-1:0];
  assign step_ovf  = |step_full[FULL_W-1:BIN_W];
  assign accept    = (state_q == IDLE) && !rst_i && bus.in_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= bus.dat_bcd_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= CONV;
          end
        end
        CONV: begin
          acc_q   <= step_res;
          err_q   <= err_q | (dig > 4'd9);
          ovf_q   <= ovf_q | step_ovf;
          shift_q <= shift_q << 4;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (bus.out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_GRAY_EN
  logic [BIN_W-1:0] gray_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gray_q <= '0;
    end else if (state_q == CONV && cnt_q == LAST) begin
      gray_q <= step_res ^ (step_res >> 1);
    end
  end

  assign bus.dat_gray_o = gray_q;
`endif

  assign bus.in_ready_o  = (state_q == IDLE) && !rst_i;
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.dat_bin_o   = acc_q;
  assign bus.err_o       = err_q;
  assign bus.ovf_o       = ovf_q;
endmodule
